// File: rtl/adder_pkg.sv
// Shared definitions for the 381-bit add-and-transmit sequencer:
// state encodings and the default watchdog limit.
package adder_pkg;

    localparam int STATE_W            = 3;
    localparam int TIMEOUT_CYCLES_DEF = 50_000_000;  // 0.5 s at 100 MHz

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_RX_A     = 3'd1,
        ST_RX_B     = 3'd2,
        ST_ADD_GO   = 3'd3,
        ST_ADD_WAIT = 3'd4,
        ST_TX_GO    = 3'd5,
        ST_TX_WAIT  = 3'd6,
        ST_DONE     = 3'd7
    } state_e;

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector: rise is high while d is high and was low
// at the previous clk edge. Synchronous active-low reset.
module rise_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    always_comb d_d = d;

    always_ff @(posedge clk) begin
        if (!reset) d_q <= 1'b0;
        else        d_q <= d_d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencer for rx A -> rx B -> add -> tx. Moore outputs are registered.
// Optional per-phase watchdog enabled by defining ADDER_SEQ_TIMEOUT_EN.
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int RUN_CNT_W      = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TO_CNT_W       = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 abort,
    input  logic                 rx_a_done,
    input  logic                 rx_b_done,
    input  logic                 add_done,
    input  logic                 tx_done,
    output logic                 en_rx_a,
    output logic                 en_rx_b,
    output logic                 start_add,
    output logic                 start_tx,
    output logic                 busy,
    output logic                 seq_done,
    output logic                 err_timeout,
    output logic [STATE_W-1:0]   state_o,
    output logic [RUN_CNT_W-1:0] run_count
);

    state_e               state_q, state_d;
    logic [RUN_CNT_W-1:0] run_count_q, run_count_d;
    logic en_rx_a_q, en_rx_a_d, en_rx_b_q, en_rx_b_d;
    logic start_add_q, start_add_d, start_tx_q, start_tx_d;
    logic busy_q, busy_d, seq_done_q, seq_done_d;
    logic rise_a, rise_b, rise_add, rise_tx;
    logic wait_st, phase_rise, expire;

    rise_det u_rise_a   (.clk(clk), .reset(reset), .d(rx_a_done), .rise(rise_a));
    rise_det u_rise_b   (.clk(clk), .reset(reset), .d(rx_b_done), .rise(rise_b));
    rise_det u_rise_add (.clk(clk), .reset(reset), .d(add_done),  .rise(rise_add));
    rise_det u_rise_tx  (.clk(clk), .reset(reset), .d(tx_done),   .rise(rise_tx));

`ifdef ADDER_SEQ_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic                err_q, err_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(TIMEOUT_CYCLES), 32'(TO_CNT_W)};
`endif

    always_comb begin
        wait_st    = 1'b0;
        phase_rise = 1'b0;
        case (state_q)
            ST_RX_A:     begin wait_st = 1'b1; phase_rise = rise_a;   end
            ST_RX_B:     begin wait_st = 1'b1; phase_rise = rise_b;   end
            ST_ADD_WAIT: begin wait_st = 1'b1; phase_rise = rise_add; end
            ST_TX_WAIT:  begin wait_st = 1'b1; phase_rise = rise_tx;  end
            default: ;
        endcase

`ifdef ADDER_SEQ_TIMEOUT_EN
        // A done edge on the expiry cycle still completes the phase.
        expire = wait_st && (to_cnt_q == TO_LAST) && !phase_rise;
`else
        expire = 1'b0;
`endif

        state_d     = state_q;
        run_count_d = run_count_q;
        case (state_q)
            ST_IDLE:     if (go)         state_d = ST_RX_A;
            ST_RX_A:     if (phase_rise) state_d = ST_RX_B;
            ST_RX_B:     if (phase_rise) state_d = ST_ADD_GO;
            ST_ADD_GO:                   state_d = ST_ADD_WAIT;
            ST_ADD_WAIT: if (phase_rise) state_d = ST_TX_GO;
            ST_TX_GO:                    state_d = ST_TX_WAIT;
            ST_TX_WAIT:  if (phase_rise) state_d = ST_DONE;
            ST_DONE: begin
                state_d     = ST_IDLE;
                run_count_d = run_count_q + RUN_CNT_W'(1);
            end
            default:                     state_d = ST_IDLE;
        endcase
        if (expire) state_d = ST_IDLE;
        if (abort) begin
            state_d     = ST_IDLE;
            run_count_d = run_count_q;
        end

`ifdef ADDER_SEQ_TIMEOUT_EN
        err_d = err_q;
        if (expire && !abort)
            err_d = 1'b1;
        else if (state_q == ST_IDLE && state_d == ST_RX_A)
            err_d = 1'b0;
        to_cnt_d = (state_d != state_q || !wait_st) ? '0 : to_cnt_q + TO_CNT_W'(1);
`endif

        en_rx_a_d   = (state_d == ST_RX_A);
        en_rx_b_d   = (state_d == ST_RX_B);
        start_add_d = (state_d == ST_ADD_GO);
        start_tx_d  = (state_d == ST_TX_GO);
        busy_d      = (state_d != ST_IDLE);
        seq_done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            run_count_q <= '0;
            en_rx_a_q   <= 1'b0;
            en_rx_b_q   <= 1'b0;
            start_add_q <= 1'b0;
            start_tx_q  <= 1'b0;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
`ifdef ADDER_SEQ_TIMEOUT_EN
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            run_count_q <= run_count_d;
            en_rx_a_q   <= en_rx_a_d;
            en_rx_b_q   <= en_rx_b_d;
            start_add_q <= start_add_d;
            start_tx_q  <= start_tx_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
`ifdef ADDER_SEQ_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign en_rx_a   = en_rx_a_q;
    assign en_rx_b   = en_rx_b_q;
    assign start_add = start_add_q;
    assign start_tx  = start_tx_q;
    assign busy      = busy_q;
    assign seq_done  = seq_done_q;
    assign state_o   = state_q;
    assign run_count = run_count_q;
`ifdef ADDER_SEQ_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: expected run counts are queued at go
// and popped on each seq_done; state walk and pulses are checked directly.
module tb_adder_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, go, abort;
    logic [3:0] dn;
    logic       en_rx_a, en_rx_b, start_add, start_tx, busy, seq_done, err_timeout;
    logic [2:0] state_o;
    logic [1:0] run_count;

    int n_chk = 0, n_pass = 0;
    int adds = 0, txs = 0;
    int exp_runs = 0;
    int exp_q[$];
    bit auto_on = 1'b0;

    adder_seq_ctrl #(.RUN_CNT_W(2), .TIMEOUT_CYCLES(10), .TO_CNT_W(4)) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .rx_a_done(dn[0]), .rx_b_done(dn[1]), .add_done(dn[2]), .tx_done(dn[3]),
        .en_rx_a(en_rx_a), .en_rx_b(en_rx_b), .start_add(start_add),
        .start_tx(start_tx), .busy(busy), .seq_done(seq_done),
        .err_timeout(err_timeout), .state_o(state_o), .run_count(run_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int i);
        dn[i] = 1'b1;
        step();
        dn[i] = 1'b0;
    endtask

    task automatic start_seq(input bit will_finish);
        go = 1'b1;
        if (will_finish) begin
            exp_q.push_back(exp_runs & 3);
            exp_runs++;
        end
        step();
        go = 1'b0;
    endtask

    // Scoreboard consumer and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (start_add) adds++;
        if (start_tx)  txs++;
        if (seq_done) begin
            if (exp_q.size() == 0) chk("seq_extra", 1, 0);
            else                   chk("seq_cnt", 32'(run_count), exp_q.pop_front());
        end
    end

    // Instant-done responder: raise each done while its wait state is current.
    always @(posedge clk) begin
        #1;
        if (auto_on)
            dn = {state_o == 3'd6, state_o == 3'd4, state_o == 3'd2, state_o == 3'd1};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0; go = 1'b0; abort = 1'b0; dn = '0;
        repeat (3) step();
        chk("rst_state", state_o, 0);
        chk("rst_outs", {en_rx_a, en_rx_b, start_add, start_tx, busy, seq_done}, 0);
        chk("rst_runs", run_count, 0);
        chk("rst_err", err_timeout, 0);
        reset = 1'b1;
        step();

        // Full walk with one-cycle-late dones.
        start_seq(1'b1);
        chk("w_rxa", {state_o, en_rx_a, busy}, {3'd1, 2'b11});
        step();
        chk("w_rxa_hold", state_o, 1);
        pulse(0);
        chk("w_rxb", {state_o, en_rx_b, en_rx_a}, {3'd2, 2'b10});
        step();
        pulse(1);
        chk("w_addgo", {state_o, start_add}, {3'd3, 1'b1});
        step();
        chk("w_addwait", {state_o, start_add}, {3'd4, 1'b0});
        step();
        pulse(2);
        chk("w_txgo", {state_o, start_tx}, {3'd5, 1'b1});
        step();
        chk("w_txwait", {state_o, start_tx}, {3'd6, 1'b0});
        step();
        pulse(3);
        chk("w_done", {state_o, seq_done}, {3'd7, 1'b1});
        step();
        chk("w_idle", {state_o, seq_done, busy}, 0);
        chk("w_runs", run_count, 1);
        chk("w_pulses", {8'(adds), 8'(txs)}, {8'd1, 8'd1});

        // Stale add_done held high across ADD_WAIT entry.
        start_seq(1'b1);
        dn[2] = 1'b1;
        pulse(0);
        pulse(1);
        step();
        repeat (3) step();
        chk("stale_hold", state_o, 4);
        dn[2] = 1'b0;
        step();
        chk("stale_low", state_o, 4);
        dn[2] = 1'b1;
        step();
        chk("stale_rise", state_o, 5);
        dn[2] = 1'b0;
        step();
        pulse(3);
        step();
        chk("stale_runs", run_count, 2);
        chk("stale_tx", txs, 2);

        // Abort in ADD_WAIT, then abort in IDLE.
        start_seq(1'b0);
        pulse(0);
        pulse(1);
        step();
        chk("ab_pre", state_o, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle", {state_o, busy}, 0);
        repeat (2) step();
        chk("ab_tx", txs, 2);
        chk("ab_runs", run_count, 2);
        abort = 1'b1; go = 1'b1;
        step();
        abort = 1'b0; go = 1'b0;
        chk("ab_go_idle", state_o, 0);

        // Reset asserted while in TX_GO.
        start_seq(1'b0);
        pulse(0);
        pulse(1);
        step();
        pulse(2);
        chk("rs_txgo", {state_o, start_tx}, {3'd5, 1'b1});
        reset = 1'b0;
        step();
        chk("rs_outs", {state_o, en_rx_a, en_rx_b, start_add, start_tx, busy, seq_done}, 0);
        chk("rs_runs", run_count, 0);
        exp_runs = 0;
        reset = 1'b1;
        step();
        chk("rs_pulses", {8'(adds), 8'(txs)}, {8'd4, 8'd3});

        // Back-to-back with go held and instant dones: 5 runs wrap 2-bit count.
        auto_on = 1'b1;
        go = 1'b1;
        for (int r = 0; r < 5; r++) begin
            exp_q.push_back(exp_runs & 3);
            exp_runs++;
        end
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("b2b_st%0d", k), state_o, 32'(k % 8));
            if (k == 24) chk("b2b_runs3", run_count, 3);
            step();
        end
        go = 1'b0;
        auto_on = 1'b0;
        dn = '0;
        step();
        chk("b2b_idle", state_o, 0);
        chk("b2b_runs5", run_count, 1);

`ifdef ADDER_SEQ_TIMEOUT_EN
        // Watchdog expiry in RX_B, then edge on the expiry cycle wins.
        start_seq(1'b0);
        pulse(0);
        chk("to_rxb", state_o, 2);
        for (int c = 1; c < 10; c++) step();
        chk("to_pre", {state_o, err_timeout}, {3'd2, 1'b0});
        step();
        chk("to_exp", {state_o, err_timeout}, {3'd0, 1'b1});
        repeat (3) step();
        chk("to_sticky", err_timeout, 1);
        start_seq(1'b1);
        chk("to_clr", {state_o, err_timeout}, {3'd1, 1'b0});
        pulse(0);
        for (int c = 1; c < 10; c++) step();
        pulse(1);
        chk("to_edge_wins", {state_o, err_timeout}, {3'd3, 1'b0});
        step();
        pulse(2);
        step();
        pulse(3);
        step();
        chk("to_runs", run_count, 2);
`else
        chk("err_tied", err_timeout, 0);
`endif

        step();
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencing controller for the 381-bit add-and-transmit datapath.
- Drives the two UART receive loads (operand A, then operand B), the adder start, and the serial Tx start, in that order.
- Reports overall busy and completion to the host-facing logic.
- Sits in the top-level adder module, between the external control pins and the rx, adder and Tx_381bit instances.

Parameters:
RUN_CNT_W, 16, width of the completed-run counter
TIMEOUT_CYCLES, 50_000_000, per-phase watchdog limit in clk cycles (used only with the optional feature)
TO_CNT_W, 26, watchdog counter width; must satisfy 2**TO_CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-low reset
go  in  1  start one full sequence; level, sampled only in IDLE
abort  in  1  return to IDLE from any state next cycle
rx_a_done  in  1  operand A received (level from rx instance)
rx_b_done  in  1  operand B received (level)
add_done  in  1  adder finished (level)
tx_done  in  1  transmit finished (level)
en_rx_a  out  1  enable for operand-A receiver
en_rx_b  out  1  enable for operand-B receiver
start_add  out  1  one-cycle adder start pulse
start_tx  out  1  one-cycle Tx start pulse
busy  out  1  high in every state except IDLE
seq_done  out  1  one-cycle pulse when a sequence completes
err_timeout  out  1  sticky watchdog error; tied 0 without the feature
state_o  out  3  current state encoding, for debug LEDs
run_count  out  RUN_CNT_W  number of completed sequences, wraps

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs 0, run_count=0, edge registers=0.
  - Reset mid-sequence aborts immediately; no pulse is emitted on the reset cycle.
- States and encodings: IDLE=0, RX_A=1, RX_B=2, ADD_GO=3, ADD_WAIT=4, TX_GO=5, TX_WAIT=6, DONE=7.
- Done-input handling:
  - Each done input is registered every cycle (d_q).
  - A phase completes only on a rising edge (d & ~d_q) seen while in the matching wait state.
  - Stale high levels left over from a previous run are therefore ignored.
- Transitions:
  - IDLE: go=1 -> RX_A.
  - RX_A: en_rx_a=1; rising edge of rx_a_done -> RX_B.
  - RX_B: en_rx_b=1; rising edge of rx_b_done -> ADD_GO.
  - ADD_GO: start_add=1 for exactly this cycle -> ADD_WAIT.
  - ADD_WAIT: rising edge of add_done -> TX_GO.
  - TX_GO: start_tx=1 for exactly this cycle -> TX_WAIT.
  - TX_WAIT: rising edge of tx_done -> DONE.
  - DONE: seq_done=1 for one cycle; run_count increments (wraps at all-ones -> 0) -> IDLE.
- Outputs are Moore, decoded from registered state. Enables are high for the whole RX_A/RX_B state, including the cycle the done edge is seen.
- Latency: go in IDLE to start_add is 2 cycles plus the receive times. With all done edges arriving immediately, go to seq_done is 7 cycles minimum.
- abort:
  - Has priority over every transition except reset.
  - Next state is IDLE and all enables/pulses drop.
  - seq_done is not pulsed and run_count is unchanged.
  - abort in IDLE is a no-op.
- go held high: after DONE returns to IDLE, a new sequence starts on the next cycle (back-to-back operation allowed).
- A done edge arriving in a state other than its wait state is discarded, not queued.

Optional Feature:
Macro: ADDER_SEQ_TIMEOUT_EN
- Defined:
  - A per-phase counter clears on every state change and increments in RX_A, RX_B, ADD_WAIT and TX_WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without the phase completing, the next state is IDLE and err_timeout is set.
  - err_timeout stays high until the next accepted go (cleared on the IDLE->RX_A transition) or reset.
  - A done edge on the same cycle as expiry wins: the phase completes and no error is raised.
- Undefined: no counter logic; err_timeout is constant 0; the sequence waits indefinitely.

Decomposition:
- Shared package adder_pkg holds:
  - state enum/localparams (3-bit encodings above)
  - STATE_W=3
  - default TIMEOUT_CYCLES for a 100 MHz clk
- Sub-module rise_det (1-bit registered rising-edge detector with synchronous active-low reset), instantiated four times.
- The FSM, counters and output decode stay in adder_seq_ctrl.

Test Plan:
- Reset held low 3 cycles, then go=1 with all done inputs pulsed 1 cycle after entering each wait state -> state_o walks 1..7, start_add and start_tx each exactly 1 cycle high, seq_done 1 cycle, run_count=1.
- add_done held high from a previous run when entering ADD_WAIT -> no transition until add_done falls then rises; exactly one start_tx.
- abort=1 in ADD_WAIT -> next cycle state_o=0, busy=0, no start_tx, run_count unchanged.
- reset=0 asserted in TX_GO -> start_tx=0 that cycle edge, all outputs 0 next cycle.
- go held high, 3 sequences with instant dones -> run_count=3; IDLE occupied exactly 1 cycle between sequences; with RUN_CNT_W=2, 5 runs -> run_count=1.
- ADDER_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=10, no rx_b_done -> IDLE after 10 cycles in RX_B, err_timeout=1 until next go; a rx_b_done edge on cycle 10 -> ADD_GO, err_timeout=0.
